// File: rtl/elevator_car_model.sv
// Behavioural elevator car plant for a 3-floor shaft. It takes the controller's engine and
// door commands. Tick counters model car travel and door motion, and the block reports floor
// sensors, door status, arrival pulses and a sticky fault.
//
// Ports:
//   CLK             clock, rising edge
//   RST             asynchronous reset, active low
//   engine_i[1:0]   00 off, 10 up, 11 down, 01 treated as off
//   doors_i[2:0]    one-hot door-open command, bit 0 = 1st floor
//   floor_sensor_o  one-hot parked floor, 000 while moving
//   door_open_o     one-hot, set only while the door is fully open
//   car_moving_o    high while travelling
//   arrived_o       single-cycle pulse when the car lands on a floor
//   fault_o         sticky fault flag
//   fault_code_o    01 overtravel/reversal, 10 door cmd wrong floor, 11 motion with door not closed
module elevator_car_model #(
  parameter int unsigned TRAVEL_TICKS = 8,
  parameter int unsigned DOOR_TICKS   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] engine_i,
  input  logic [2:0] doors_i,
  output logic [2:0] floor_sensor_o,
  output logic [2:0] door_open_o,
  output logic       car_moving_o,
  output logic       arrived_o,
  output logic       fault_o,
  output logic [1:0] fault_code_o
);

  localparam int unsigned MaxTicks = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks);

  typedef enum logic [2:0] {
    StParked, StOpening, StOpen, StClosing, StMoveUp, StMoveDn, StFault
  } state_e;

  state_e          state_q;
  logic [1:0]      floor_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      floor_sensor_q;
  logic [2:0]      door_open_q;
  logic            car_moving_q;
  logic            arrived_q;
  logic            fault_q;
  logic [1:0]      fault_code_q;

  function automatic logic [2:0] onehot(input logic [1:0] f);
    onehot = 3'b001 << f;
  endfunction

  logic [2:0] own;
  logic       eng_up, eng_dn, eng_mv, door_cmd, own_door, stray_door;
  logic       door_done, seg_done;
  logic [1:0] floor_up, floor_dn;
  logic       flt_req;
  logic [1:0] flt_code;

  always_comb begin
    own        = onehot(floor_q);
    eng_up     = (engine_i == 2'b10);
    eng_dn     = (engine_i == 2'b11);
    eng_mv     = eng_up | eng_dn;
    door_cmd   = |doors_i;
    own_door   = |(doors_i & own);
    stray_door = |(doors_i & ~own);
    door_done  = (cnt_q == CntW'(DOOR_TICKS - 1));
    seg_done   = (cnt_q == CntW'(TRAVEL_TICKS - 1));
    floor_up   = floor_q + 2'd1;
    floor_dn   = floor_q - 2'd1;

    // Fault detection per state, in the same priority order as the state transitions.
    flt_req  = 1'b0;
    flt_code = 2'b00;
    case (state_q)
      StParked: begin
        if (door_cmd && eng_mv) begin
          flt_req = 1'b1; flt_code = 2'b11;
        end else if (door_cmd && (doors_i != own)) begin
          flt_req = 1'b1; flt_code = 2'b10;
        end else if (!door_cmd && eng_up && (floor_q == 2'd2)) begin
          flt_req = 1'b1; flt_code = 2'b01;
        end else if (!door_cmd && eng_dn && (floor_q == 2'd0)) begin
          flt_req = 1'b1; flt_code = 2'b01;
        end
      end
      StOpening, StOpen, StClosing: begin
        if (eng_mv) begin
          flt_req = 1'b1; flt_code = 2'b11;
        end else if (stray_door) begin
          flt_req = 1'b1; flt_code = 2'b10;
        end
      end
      StMoveUp, StMoveDn: begin
        // Landing wins over any command seen on the arrival cycle.
        if (!seg_done) begin
          if ((state_q == StMoveUp && eng_dn) || (state_q == StMoveDn && eng_up)) begin
            flt_req = 1'b1; flt_code = 2'b01;
          end else if (door_cmd) begin
            flt_req = 1'b1; flt_code = 2'b11;
          end
        end
      end
      default: ;
    endcase
    if ((state_q != StFault) && (floor_q == 2'd3)) begin
      flt_req  = 1'b1;
      flt_code = 2'b01;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= StParked;
      floor_q        <= 2'd0;
      cnt_q          <= '0;
      floor_sensor_q <= 3'b001;
      door_open_q    <= 3'b000;
      car_moving_q   <= 1'b0;
      arrived_q      <= 1'b0;
      fault_q        <= 1'b0;
      fault_code_q   <= 2'b00;
    end else begin
      arrived_q <= 1'b0;
      if (flt_req) begin
        // floor_sensor keeps its value: the last floor, or 000 when stopped mid-shaft.
        state_q      <= StFault;
        fault_q      <= 1'b1;
        fault_code_q <= flt_code;
        car_moving_q <= 1'b0;
        door_open_q  <= 3'b000;
      end else begin
        case (state_q)
          StParked: begin
            if (doors_i == own) begin
              state_q <= StOpening;
              cnt_q   <= '0;
            end else if (eng_up || eng_dn) begin
              state_q        <= eng_up ? StMoveUp : StMoveDn;
              cnt_q          <= '0;
              car_moving_q   <= 1'b1;
              floor_sensor_q <= 3'b000;
            end
          end
          StOpening: begin
            if (door_done) begin
              state_q     <= StOpen;
              door_open_q <= own;
            end else if (!own_door) begin
              state_q <= StClosing;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StOpen: begin
            if (!own_door) begin
              state_q     <= StClosing;
              cnt_q       <= '0;
              door_open_q <= 3'b000;
            end
          end
          StClosing: begin
            if (door_done) begin
              state_q <= StParked;
            end else if (own_door) begin
              state_q <= StOpening;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StMoveUp, StMoveDn: begin
            // Engine off mid-segment is ignored: the car always coasts to the next floor.
            if (seg_done) begin
              floor_q        <= (state_q == StMoveUp) ? floor_up : floor_dn;
              floor_sensor_q <= onehot((state_q == StMoveUp) ? floor_up : floor_dn);
              state_q        <= StParked;
              cnt_q          <= '0;
              car_moving_q   <= 1'b0;
              arrived_q      <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign floor_sensor_o = floor_sensor_q;
  assign door_open_o    = door_open_q;
  assign car_moving_o   = car_moving_q;
  assign arrived_o      = arrived_q;
  assign fault_o        = fault_q;
  assign fault_code_o   = fault_code_q;

endmodule

// File: tb/tb_elevator_car_model.sv
module tb_elevator_car_model;

  localparam int T = 8;
  localparam int D = 4;

  logic       CLK;
  logic       RST;
  logic [1:0] engine;
  logic [2:0] doors;
  logic [2:0] floor_sensor;
  logic [2:0] door_open;
  logic       car_moving;
  logic       arrived;
  logic       fault;
  logic [1:0] fault_code;

  elevator_car_model #(.TRAVEL_TICKS(T), .DOOR_TICKS(D)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .engine_i       (engine),
    .doors_i        (doors),
    .floor_sensor_o (floor_sensor),
    .door_open_o    (door_open),
    .car_moving_o   (car_moving),
    .arrived_o      (arrived),
    .fault_o        (fault),
    .fault_code_o   (fault_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: car activity, position and timers kept as plain integers.
  localparam int MdParked  = 0;
  localparam int MdOpening = 1;
  localparam int MdOpen    = 2;
  localparam int MdClosing = 3;
  localparam int MdMoving  = 4;
  localparam int MdFault   = 5;

  int m_mode, m_floor, m_timer, m_dir, m_code;
  bit m_arr, m_mid;

  task automatic model_reset();
    m_mode = MdParked; m_floor = 0; m_timer = 0; m_dir = 0;
    m_code = 0; m_arr = 0; m_mid = 0;
  endtask

  task automatic model_fault(input int code);
    m_mid  = (m_mode == MdMoving);
    m_mode = MdFault;
    m_code = code;
  endtask

  task automatic model_step(input logic [1:0] eng, input logic [2:0] drs);
    bit up, dn;
    int mine;
    up   = (eng == 2'b10);
    dn   = (eng == 2'b11);
    mine = 1 << m_floor;
    m_arr = 0;
    case (m_mode)
      MdParked: begin
        if (drs != 0 && (up || dn)) model_fault(3);
        else if (drs != 0 && int'(drs) != mine) model_fault(2);
        else if (int'(drs) == mine) begin m_mode = MdOpening; m_timer = 0; end
        else if (up) begin
          if (m_floor == 2) model_fault(1);
          else begin m_mode = MdMoving; m_dir = 1; m_timer = 0; end
        end else if (dn) begin
          if (m_floor == 0) model_fault(1);
          else begin m_mode = MdMoving; m_dir = -1; m_timer = 0; end
        end
      end
      MdOpening, MdOpen, MdClosing: begin
        if (up || dn) model_fault(3);
        else if ((int'(drs) & ~mine) != 0) model_fault(2);
        else if (m_mode == MdOpening) begin
          if (m_timer == D - 1) m_mode = MdOpen;
          else if ((int'(drs) & mine) == 0) begin m_mode = MdClosing; m_timer = 0; end
          else m_timer++;
        end else if (m_mode == MdOpen) begin
          if ((int'(drs) & mine) == 0) begin m_mode = MdClosing; m_timer = 0; end
        end else begin
          if (m_timer == D - 1) m_mode = MdParked;
          else if ((int'(drs) & mine) != 0) begin m_mode = MdOpening; m_timer = 0; end
          else m_timer++;
        end
      end
      MdMoving: begin
        if (m_timer == T - 1) begin
          m_floor += m_dir; m_arr = 1; m_mode = MdParked; m_timer = 0;
        end else if ((m_dir > 0 && dn) || (m_dir < 0 && up)) model_fault(1);
        else if (drs != 0) model_fault(3);
        else m_timer++;
      end
      default: ;
    endcase
  endtask

  function automatic logic [10:0] model_outs();
    logic [2:0] fs, dop;
    fs  = 3'(1 << m_floor);
    dop = 3'b000;
    if (m_mode == MdMoving || (m_mode == MdFault && m_mid)) fs = 3'b000;
    if (m_mode == MdOpen) dop = 3'(1 << m_floor);
    return {fs, dop, m_mode == MdMoving, m_arr, m_mode == MdFault, 2'(m_code)};
  endfunction

  function automatic logic [10:0] dut_outs();
    return {floor_sensor, door_open, car_moving, arrived, fault, fault_code};
  endfunction

  int arr_cnt;

  task automatic cycle(input logic [1:0] eng, input logic [2:0] drs);
    engine = eng;
    doors  = drs;
    @(posedge CLK);
    model_step(eng, drs);
    #1;
    check("outs", 32'(dut_outs()), 32'(model_outs()));
    if (arrived === 1'b1) arr_cnt++;
  endtask

  // Asserts RST off-edge, checks the asynchronous effect, holds 3 edges, releases off-edge.
  task automatic do_reset();
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    check("rst_async", 32'(dut_outs()), 32'({3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00}));
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  task automatic go_floor2();
    repeat (2 * T + 2) cycle(2'b10, 3'b000);
    cycle(2'b00, 3'b000);
  endtask

  initial begin
    logic [1:0] eng;
    logic [2:0] drs;
    int hold;
    int fault_age;
    RST = 1'b0; engine = 2'b00; doors = 3'b000;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_vals", 32'(dut_outs()), 32'({3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00}));

    // Door opens DOOR_TICKS+1 cycles after reset release.
    doors = 3'b001;
    RST   = 1'b1;
    for (int k = 1; k <= D + 1; k++) begin
      cycle(2'b00, 3'b001);
      check("post_rst_door", 32'(door_open), (k == D + 1) ? 32'h1 : 32'h0);
      check("post_rst_fs", 32'(floor_sensor), 32'h1);
    end
    repeat (D + 1) cycle(2'b00, 3'b000);

    // Up trip: two segments.
    arr_cnt = 0;
    go_floor2();
    check("up_arrivals", arr_cnt, 2);
    check("up_fs", 32'(floor_sensor), 32'h4);

    // Coast: engine released after 3 cycles, car still lands at floor 1.
    arr_cnt = 0;
    repeat (3) cycle(2'b11, 3'b000);
    repeat (T) cycle(2'b00, 3'b000);
    check("coast_arrivals", arr_cnt, 1);
    check("coast_fs", 32'(floor_sensor), 32'h2);

    // Reopen at floor 1.
    arr_cnt = 0;
    repeat (D + 1) cycle(2'b00, 3'b010);
    check("reopen_open1", 32'(door_open), 32'h2);
    repeat (2) cycle(2'b00, 3'b000);
    check("reopen_closing", 32'(door_open), 32'h0);
    repeat (D + 1) cycle(2'b00, 3'b010);
    check("reopen_open2", 32'(door_open), 32'h2);
    check("reopen_noarr", arr_cnt, 0);
    repeat (D + 1) cycle(2'b00, 3'b000);

    // Overtravel at floor 2.
    do_reset();
    go_floor2();
    cycle(2'b10, 3'b000);
    check("ovt_code", 32'({fault, fault_code}), 32'({1'b1, 2'b01}));
    repeat (4) cycle(2'b11, 3'b001);
    check("ovt_sticky", 32'({fault, fault_code, floor_sensor}), 32'({1'b1, 2'b01, 3'b100}));

    // Wrong-floor door command.
    do_reset();
    cycle(2'b00, 3'b100);
    check("wrong_door", 32'({fault, fault_code}), 32'({1'b1, 2'b10}));
    repeat (3) cycle(2'b10, 3'b001);
    check("wrong_sticky", 32'({fault, fault_code}), 32'({1'b1, 2'b10}));

    // Engine while the door is open.
    do_reset();
    repeat (D + 2) cycle(2'b00, 3'b001);
    cycle(2'b10, 3'b001);
    check("eng_open", 32'({fault, fault_code, door_open}), 32'({1'b1, 2'b11, 3'b000}));

    // Reset mid-travel at cnt=4.
    do_reset();
    repeat (5) cycle(2'b10, 3'b000);
    check("mid_moving", 32'(car_moving), 32'h1);
    do_reset();
    check("mid_rst_fs", 32'({floor_sensor, car_moving}), 32'({3'b001, 1'b0}));

    // Randomized closed-loop traffic.
    fault_age = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 6) eng = 2'b00;
      else eng = 2'($urandom_range(1, 3));
      case ($urandom_range(0, 9))
        6, 7, 8: drs = 3'(1 << m_floor);
        9:       drs = 3'($urandom_range(0, 7));
        default: drs = 3'b000;
      endcase
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) begin
        cycle(eng, drs);
        n++;
      end
      if (m_mode == MdFault) fault_age++;
      if (fault_age > 3 || $urandom_range(0, 99) == 0) begin
        do_reset();
        fault_age = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
